// File: rtl/ofmd_wr_addr_if.sv
// ofmd_wr_addr_if: handshake and buffer-write bundle for the OFMD write controller
interface ofmd_wr_addr_if #(
  parameter int WIDTH  = 6,
  parameter int DATA_W = 16
);
  logic              start;
  logic              is_5x5;
  logic              relu_en;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              wr_en;
  logic [WIDTH-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done_wr;
  logic              ovf_err;
  modport master (
    output start, is_5x5, relu_en, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done_wr, ovf_err
  );
  modport slave (
    input  start, is_5x5, relu_en, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, busy, done_wr, ovf_err
  );
endinterface

// File: rtl/ofmd_wr_addr.sv
// ofmd_wr_addr: OFMD buffer write-address controller with optional ReLU and end-of-frame pulse
module ofmd_wr_addr #(
  parameter int WIDTH      = 6,
  parameter int DATA_W     = 16,
  parameter int OFMD1_SIZE = 36,
  parameter int OFMD2_SIZE = 16
) (
  input logic         clk,
  input logic         rst,
  ofmd_wr_addr_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] max_addr;
  logic             mode;
  logic             relu;
  assign max_addr     = mode ? WIDTH'(OFMD2_SIZE - 1) : WIDTH'(OFMD1_SIZE - 1);
  assign bus.in_ready = state == WRITE;
  assign bus.busy     = state != IDLE;
  assign bus.done_wr  = state == DONE;
  // frame sequencing, write-port register stage and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      mode        <= 1'b0;
      relu        <= 1'b0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.ovf_err <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            mode        <= bus.is_5x5;
            relu        <= bus.relu_en;
            cnt         <= '0;
            bus.ovf_err <= 1'b0;
            state       <= WRITE;
          end else if (bus.in_valid) begin
            bus.ovf_err <= 1'b1;
          end
        end
        WRITE: begin
          if (bus.in_valid) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= cnt;
            bus.wr_data <= (relu && bus.in_data[DATA_W-1]) ? '0 : bus.in_data;
            if (cnt == max_addr) state <= DONE;
            else cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.in_valid) bus.ovf_err <= 1'b1;
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ofmd_wr_addr.sv
// tb_ofmd_wr_addr: scoreboard bench for the OFMD write-address controller
module tb_ofmd_wr_addr;
  typedef struct {
    logic [5:0]  addr;
    logic [15:0] data;
    logic        last;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  ofmd_wr_addr_if #(.WIDTH(6), .DATA_W(16)) bus ();
  ofmd_wr_addr #(.WIDTH(6), .DATA_W(16), .OFMD1_SIZE(36), .OFMD2_SIZE(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int frames = 0;
  int exp_addr = 0;
  int size = 36;
  bit cur_relu = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] relu_f(input logic [15:0] d, input bit r);
    return (r && d[15]) ? 16'h0000 : d;
  endfunction
  // monitor: every write must match the head of the scoreboard, done only with the last write
  always @(negedge clk) begin
    if (bus.done_wr) done_cnt++;
    if (bus.wr_en) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_write: got addr %0d data %0h, no write expected", bus.wr_addr, bus.wr_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
        chk("wr_data", 32'(bus.wr_data), 32'(e.data));
        chk("done_with_write", 32'(bus.done_wr), 32'(e.last));
      end
    end else if (bus.done_wr) begin
      checks++;
      errors++;
      $display("FAIL done_without_write: got done_wr 1 expected 0");
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic begin_frame(input bit m, input bit r, input bit v);
    bus.start = 1'b1;
    bus.is_5x5 = m;
    bus.relu_en = r;
    bus.in_valid = v;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    cur_relu = r;
    exp_addr = 0;
    size = m ? 16 : 36;
    chk("in_ready_write", 32'(bus.in_ready), 32'd1);
    chk("busy_write", 32'(bus.busy), 32'd1);
  endtask
  task automatic accept(input logic [15:0] d);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    q.push_back('{addr: 6'(exp_addr), data: relu_f(d, cur_relu), last: exp_addr == size - 1});
    exp_addr++;
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic check_idle();
    frames++;
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("done_count", 32'(done_cnt), 32'(frames));
    chk("in_ready_idle", 32'(bus.in_ready), 32'd0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
  endtask
  task automatic end_frame();
    tick();
    check_idle();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start = 1'b0;
    bus.is_5x5 = 1'b0;
    bus.relu_en = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 16'h0;
    repeat (3) tick();
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
    chk("rst_flags", 32'({bus.in_ready, bus.busy, bus.done_wr, bus.ovf_err}), 32'd0);
    rst = 1'b0;
    tick();
    // 3x3 frame, back-to-back, data 100..135
    begin_frame(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 36; i++) accept(16'(100 + i));
    chk("done_state", 32'(bus.done_wr), 32'd1);
    chk("ovf_clean", 32'(bus.ovf_err), 32'd0);
    end_frame();
    // 5x5 frame with gaps and is_5x5 toggled mid-frame
    begin_frame(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      accept(16'(200 + i));
      bus.is_5x5 = ~bus.is_5x5;
      if (i < 15) tick();
    end
    end_frame();
    // ReLU on: -5 -> 0, +7 -> 7
    begin_frame(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) accept(i[0] ? 16'h0007 : 16'hFFFB);
    end_frame();
    // ReLU off: -5 passes as 0xFFFB
    begin_frame(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) accept(i[0] ? 16'h0007 : 16'hFFFB);
    end_frame();
    // stray valid in IDLE sets a sticky overflow
    bus.in_valid = 1'b1;
    bus.in_data = 16'h0055;
    tick();
    bus.in_valid = 1'b0;
    chk("ovf_idle", 32'(bus.ovf_err), 32'd1);
    tick();
    chk("ovf_sticky", 32'(bus.ovf_err), 32'd1);
    // start with simultaneous valid clears it; start at accept 10 is ignored
    begin_frame(1'b0, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(bus.ovf_err), 32'd0);
    for (int i = 0; i < 36; i++) begin
      bus.start = (i == 10);
      accept(16'(300 + i));
      bus.start = 1'b0;
    end
    chk("ovf_in_frame", 32'(bus.ovf_err), 32'd0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check_idle();
    chk("ovf_done", 32'(bus.ovf_err), 32'd1);
    // reset after accept 20: no pending write, no done
    begin_frame(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) accept(16'(400 + i));
    rst = 1'b1;
    tick();
    chk("mid_rst_outputs", 32'({bus.wr_en, bus.in_ready, bus.busy, bus.done_wr, bus.ovf_err}), 32'd0);
    chk("mid_rst_addr", 32'(bus.wr_addr), 32'd0);
    chk("mid_rst_data", 32'(bus.wr_data), 32'd0);
    rst = 1'b0;
    tick();
    chk("mid_rst_no_done", 32'(done_cnt), 32'(frames));
    chk("mid_rst_drained", 32'(q.size()), 32'd0);
    begin_frame(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) accept(16'(500 + i));
    end_frame();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ofmd_wr_addr.md
# ofmd_wr_addr

Write-side controller for the output feature map (OFMD) buffer. It accepts convolution results one per handshake from the MAC datapath and generates sequential buffer write addresses for a 6x6 frame (3x3 kernel, 36 entries) or a 4x4 frame (5x5 kernel, 16 entries). It drives the buffer write port through one register stage and optionally applies ReLU. At end of frame it pulses `done_wr`, which is the hand-off to the OFMD read-address counter.

## Interface
- `WIDTH`, 6, width of the address counter and `wr_addr`
- `DATA_W`, 16, result width (two's complement)
- `OFMD1_SIZE`, 36, entries per frame for 3x3 kernel (6x6 OFMD)
- `OFMD2_SIZE`, 16, entries per frame for 5x5 kernel (4x4 OFMD)

- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  begin a frame; honoured only in IDLE
- `is_5x5`  in  1  frame size select (1 = 16 entries, 0 = 36 entries); sampled only when `start` is accepted
- `relu_en`  in  1  ReLU enable; sampled only when `start` is accepted
- `in_valid`  in  1  result valid from MAC
- `in_data`  in  DATA_W  signed result
- `in_ready`  out  1  controller accepts a result; combinational from state (1 only in WRITE)
- `wr_en`  out  1  buffer write strobe
- `wr_addr`  out  WIDTH  buffer write address
- `wr_data`  out  DATA_W  buffer write data
- `busy`  out  1  high in WRITE and DONE
- `done_wr`  out  1  one-cycle end-of-frame pulse
- `ovf_err`  out  1  sticky: a result arrived while not accepting

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: `in_ready`=0. If `start`=1: latch `is_5x5` into a mode register and `relu_en` into a ReLU register, clear the counter, clear `ovf_err`, go to WRITE.
- WRITE: `in_ready`=1. `max_addr` = mode ? OFMD2_SIZE-1 : OFMD1_SIZE-1. It is computed from the latched mode, never from the live `is_5x5`.
- Accept when `in_valid`&&`in_ready`. On each accept:
  - Register `wr_en`=1, `wr_addr`=cnt, `wr_data`=f(`in_data`).
  - f(x) = (relu && x[DATA_W-1]) ? 0 : x.
  - If cnt==`max_addr`, go to DONE. Otherwise cnt <= cnt+1.
- Cycle in WRITE with no accept: `wr_en`=0 next cycle. `wr_addr`/`wr_data` hold their last values.
- DONE: lasts exactly one cycle. `done_wr`=1, `in_ready`=0, then go to IDLE. The counter wraps to 0 on exit.
- `start` in WRITE or DONE is ignored: no restart and no error.
- `ovf_err`:
  - Set when `in_valid`=1 in IDLE or DONE.
  - Cleared only by `rst` or by an accepted `start`.
  - If `in_valid` and an accepted `start` occur in the same cycle, `start` wins and `ovf_err` stays 0.
- Addresses are strictly ascending with no gaps: 0..`max_addr`. Each address is written exactly once per frame.
- Counter arithmetic is WIDTH-bit unsigned. The counter never exceeds `max_addr`.

## Timing
- Reset values: state=IDLE, cnt=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `in_ready`=0, `busy`=0, `done_wr`=0, `ovf_err`=0, mode=0, relu=0.
- `rst` mid-frame: all of the above take effect the next edge. The pending write is dropped (no `wr_en`). `done_wr` is not emitted.
- `start` accepted at edge N: WRITE and `in_ready`=1 from cycle N+1.
- Accept at edge N: `wr_en`/`wr_addr`/`wr_data` are valid in cycle N+1 (latency 1).
- Back-to-back accepts give one write per cycle. Frame minimum duration: size accepts + 1 DONE cycle.
- The final accept at edge N produces `wr_en` and `done_wr` together in cycle N+1 (DONE state).
- Next `start` is honoured at the earliest in cycle N+2 (IDLE).

## Test plan
- 3x3 frame: `start`, `is_5x5`=0, 36 back-to-back valids with data = 100+i -> 36 writes at addr 0..35 with data 100..135. `done_wr` is high for exactly one cycle, coincident with the addr-35 write. `ovf_err`=0.
- 5x5 frame with gaps: `is_5x5`=1, `in_valid` toggled 1/0 -> 16 writes at addr 0..15. There is no `wr_en` in gap cycles. `done_wr` fires after the 16th accept. Toggling `is_5x5` mid-frame has no effect.
- ReLU: `relu_en`=1, data alternating -5/+7 -> writes 0/7. With `relu_en`=0 the same stimulus writes -5/7 (0xFFFB/0x0007).
- Stray traffic: `in_valid` in IDLE -> no `wr_en` and `ovf_err`=1. The next `start` clears it. `in_valid` in the DONE cycle also sets `ovf_err`.
- Ignored start: `start` pulsed at accept 10 of a 36-entry frame -> the frame continues to addr 35 without a counter reset.
- Reset mid-frame: `rst` after accept 20 -> all outputs 0 next cycle and no `done_wr`. A new `start` with `is_5x5`=1 then writes addr 0..15 normally.
